// File: rtl/enc_dec_engine_pipe.sv
// Two-stage mask-add cipher engine: frames plaintext as {key, data+mask, tag}
// on encrypt and recovers plaintext plus a malformed-frame flag on decrypt.
module enc_dec_engine_pipe #(
    parameter int DATA_W = 60,
    parameter int KEY_W  = 11,
    parameter int TAG_W  = 6,
    parameter logic [KEY_W-1:0] LFSR_SEED = 11'h5A5,
    parameter logic [KEY_W-1:0] LFSR_TAPS = 11'h500,
    localparam int FRAME_W = KEY_W + DATA_W + 1 + TAG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FRAME_W-1:0] in_data,
    input  logic               seed_load,
    input  logic [KEY_W-1:0]   seed_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FRAME_W-1:0] out_data,
    output logic               out_err
);

    localparam int ZERO_W = FRAME_W - TAG_W - DATA_W;

    function automatic logic [DATA_W-1:0] mask_of(input logic [KEY_W-1:0] k);
        logic [DATA_W-1:0] m;
        int s;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            s    = i / KEY_W;
            m[i] = k[i % KEY_W] ^ ((s % 5 == 2) || (s % 5 == 3));
        end
        return m;
    endfunction

    logic [KEY_W-1:0]   key;
    logic [TAG_W-1:0]   tag;
    logic               s1_valid;
    logic               s1_mode;
    logic [FRAME_W-1:0] s1_data;
    logic [KEY_W-1:0]   s1_key;
    logic [TAG_W-1:0]   s1_tag;

    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = rst_n && s1_adv;
    assign accept   = in_valid && in_ready;

    logic [DATA_W:0]   enc_x;
    logic [KEY_W-1:0]  dec_k;
    logic [DATA_W:0]   dec_x;
    logic [DATA_W+1:0] dec_p;
    logic [FRAME_W-1:0] s2_data;
    logic               s2_err;

    assign enc_x = {1'b0, s1_data[DATA_W-1:0]} + {1'b0, mask_of(s1_key)};
    assign dec_k = s1_data[FRAME_W-1 -: KEY_W];
    assign dec_x = s1_data[TAG_W +: DATA_W+1];
    assign dec_p = {1'b0, dec_x} - {2'b00, mask_of(dec_k)};

    // Sign bit catches p<0, the next bit catches p>=2^DATA_W
    always_comb begin
        s2_data = {s1_key, enc_x, s1_tag};
        s2_err  = 1'b0;
        if (s1_mode) begin
            s2_data = {{ZERO_W{1'b0}}, s1_data[TAG_W-1:0], dec_p[DATA_W-1:0]};
            s2_err  = dec_p[DATA_W+1] | dec_p[DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key       <= LFSR_SEED;
            tag       <= '0;
            s1_valid  <= 1'b0;
            s1_mode   <= 1'b0;
            s1_data   <= '0;
            s1_key    <= '0;
            s1_tag    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            if (seed_load) begin
                key <= (seed_val == '0) ? KEY_W'(1) : seed_val;
            end else if (accept && !mode) begin
                key <= {key[KEY_W-2:0], ^(key & LFSR_TAPS)};
            end
            if (accept && !mode) begin
                tag <= tag + TAG_W'(1);
            end
            if (s1_adv) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_mode <= mode;
                    s1_data <= in_data;
                    s1_key  <= key;
                    s1_tag  <= tag;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= s2_data;
                    out_err  <= s2_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_enc_dec_engine_pipe.sv
// Self-checking bench for enc_dec_engine_pipe: vector table plus
// scoreboard queue filled at accept and drained at output handshake.
module tb_enc_dec_engine_pipe;

    localparam int DW = 60;
    localparam int KW = 11;
    localparam int TW = 6;
    localparam int FW = 78;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_data;
    logic          seed_load;
    logic [KW-1:0] seed_val;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_data;
    logic          out_err;

    always #5 clk = ~clk;

    enc_dec_engine_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    typedef struct {
        logic [FW-1:0] data;
        logic [FW-1:0] exp;
    } vec_t;

    typedef struct {
        logic [FW-1:0] d;
        logic          e;
    } sb_t;

    vec_t tab[8];
    sb_t  q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    logic [KW-1:0] mkey;
    logic [TW-1:0] mtag;
    logic          hold_v = 1'b0;
    logic [FW-1:0] hold_d;
    logic          hold_e;

    // Mask layout, LSB block first: k, k, ~k, ~k, k, k[4:0]
    function automatic logic [DW-1:0] tmask(input logic [KW-1:0] k);
        return {k[4:0], k, ~k, ~k, k, k};
    endfunction

    function automatic logic [KW-1:0] tlfsr(input logic [KW-1:0] k);
        return {k[KW-2:0], k[10] ^ k[8]};
    endfunction

    function automatic logic [FW-1:0] enc_frame(input logic [KW-1:0] k,
                                                input logic [TW-1:0] t,
                                                input logic [DW-1:0] d);
        logic [DW:0] x;
        x = {1'b0, d} + {1'b0, tmask(k)};
        return {k, x, t};
    endfunction

    task automatic model_out(input logic m, input logic [FW-1:0] d,
                             output logic [FW-1:0] od, output logic oe);
        logic [DW:0] dx;
        logic [DW:0] mk;
        logic [DW:0] p;
        if (!m) begin
            od = enc_frame(mkey, mtag, d[DW-1:0]);
            oe = 1'b0;
        end else begin
            dx = d[TW +: DW+1];
            mk = {1'b0, tmask(d[FW-1 -: KW])};
            p  = dx - mk;
            oe = (dx < mk) || p[DW];
            od = {12'b0, d[TW-1:0], p[DW-1:0]};
        end
    endtask

    task automatic chk(input string nm, input logic [FW-1:0] act,
                       input logic [FW-1:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, act, req);
    endtask

    task automatic send(input logic m, input logic [FW-1:0] d,
                        input logic sl, input logic [KW-1:0] sv,
                        input logic ux, input logic [FW-1:0] xd,
                        input logic xe);
        sb_t  e;
        logic ok;
        ok = 1'b0;
        mode = m;
        in_data = d;
        seed_load = sl;
        seed_val = sv;
        in_valid = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL accept_timeout: in_ready 0 for 100 cycles required 1");
            in_valid = 1'b0;
            seed_load = 1'b0;
            return;
        end
        model_out(m, d, e.d, e.e);
        if (ux) begin
            e.d = xd;
            e.e = xe;
        end
        q.push_back(e);
        if (sl) mkey = (sv == '0) ? KW'(1) : sv;
        else if (!m) mkey = tlfsr(mkey);
        if (!m) mtag = mtag + TW'(1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seed_load = 1'b0;
    endtask

    task automatic seed_only(input logic [KW-1:0] sv);
        seed_load = 1'b1;
        seed_val = sv;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        mkey = (sv == '0) ? KW'(1) : sv;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_v) begin
                chk("hold_valid", FW'(out_valid), FW'(1));
                chk("hold_data", out_data, hold_d);
                chk("hold_err", FW'(out_err), FW'(hold_e));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious_out: got %h required none", out_data);
                end else begin
                    sb_t e;
                    e = q.pop_front();
                    chk("sb_data", out_data, e.d);
                    chk("sb_err", FW'(out_err), FW'(e.e));
                end
            end
            hold_v <= out_valid && !out_ready;
            hold_d <= out_data;
            hold_e <= out_err;
        end else begin
            hold_v <= 1'b0;
        end
    end

    initial begin
        logic [FW-1:0] frm;
        logic [DW-1:0] ones;
        logic [DW-1:0] pneg;
        logic [KW-1:0] k;
        logic [TW-1:0] t;
        logic [DW-1:0] d;

        k = 11'h5A5;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom};
            tab[i].data = {18'b0, d};
            tab[i].exp  = enc_frame(k, t, d);
            k = tlfsr(k);
            t = t + TW'(1);
        end
        ones = '1;

        rst_n = 1'b0;
        mode = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        seed_load = 1'b0;
        seed_val = '0;
        out_ready = 1'b1;
        mkey = 11'h5A5;
        mtag = '0;
        #3;
        chk("rst_in_ready", FW'(in_ready), FW'(0));
        chk("rst_out_valid", FW'(out_valid), FW'(0));
        chk("rst_out_data", out_data, FW'(0));
        chk("rst_out_err", FW'(out_err), FW'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", FW'(in_ready), FW'(1));
        @(posedge clk);
        #1;

        // seed 1, latency and key progression
        seed_only(11'h001);
        send(1'b0, '0, 1'b0, '0, 1'b1,
             {11'h001, 1'b0, tmask(11'h001), 6'h00}, 1'b0);
        @(negedge clk);
        chk("lat_c1_valid", FW'(out_valid), FW'(0));
        @(negedge clk);
        chk("lat_c2_valid", FW'(out_valid), FW'(1));
        @(posedge clk);
        #1;
        send(1'b0, FW'(60'h123456), 1'b0, '0, 1'b1,
             enc_frame(11'h002, 6'h01, 60'h123456), 1'b0);

        // full-scale carry and round trip
        seed_only(11'h7FF);
        frm = enc_frame(11'h7FF, mtag, ones);
        send(1'b0, {18'b0, ones}, 1'b0, '0, 1'b1, frm, 1'b0);
        send(1'b1, frm, 1'b0, '0, 1'b1, {12'b0, frm[TW-1:0], ones}, 1'b0);

        // underflowing decrypt, then confirm key/tag untouched
        pneg = '0 - tmask(11'h001);
        send(1'b1, {11'h001, 61'b0, 6'h05}, 1'b0, '0, 1'b1,
             {12'b0, 6'h05, pneg}, 1'b1);
        send(1'b0, FW'(60'hABC), 1'b0, '0, 1'b0, '0, 1'b0);

        // reset with a beat in flight
        send(1'b0, FW'(60'h77), 1'b0, '0, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mkey = 11'h5A5;
        mtag = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_out_valid", FW'(out_valid), FW'(0));
        end
        @(posedge clk);
        #1;

        // table stream with backpressure
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(1'b0, tab[i].data, 1'b0, '0, 1'b1, tab[i].exp, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                chk("full_in_ready", FW'(in_ready), FW'(0));
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join

        // seed with simultaneous accept
        send(1'b0, FW'(60'h5), 1'b1, 11'h000, 1'b0, '0, 1'b0);
        send(1'b0, FW'(60'h6), 1'b1, 11'h123, 1'b1,
             enc_frame(11'h001, 6'h09, 60'h6), 1'b0);
        send(1'b0, FW'(60'h7), 1'b0, '0, 1'b1,
             enc_frame(11'h123, 6'h0A, 60'h7), 1'b0);
        for (int i = 0; i < 64; i++)
            send(1'b0, FW'(i), 1'b0, '0, 1'b0, '0, 1'b0);

        // mixed modes with random sink stalls
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [DW-1:0] r;
                    r = {$urandom, $urandom};
                    if (i % 3 == 1)
                        send(1'b1, {$urandom, $urandom, $urandom}, 1'b0, '0,
                             1'b0, '0, 1'b0);
                    else
                        send(1'b0, {18'b0, r}, 1'b0, '0, 1'b0, '0, 1'b0);
                end
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;

        for (int c = 0; c < 100 && q.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", FW'(q.size()), FW'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
